// File: rtl/updown_sweep_controller_if.sv
// Bundle between the sweep controller, its host and the up/down counter it drives.
// The slave modport is the controller; the master side is host plus counter.
interface updown_sweep_controller_if #(
  parameter int BITS = 5,
  parameter int SW_W = 4
);
  // Host programming and handshake
  logic            start;
  logic            abort;
  logic [BITS-1:0] lo;
  logic [BITS-1:0] hi;
  logic [SW_W-1:0] sweeps;
  logic            busy;
  logic            done;
  logic            err;
  logic [SW_W-1:0] sweep_rem;

  // Counter control and feedback
  logic            cnt_enable;
  logic            cnt_load;
  logic            cnt_up;
  logic [BITS-1:0] cnt_d;
  logic [BITS-1:0] cnt_q;

  modport slave (
    input  start, abort, lo, hi, sweeps, cnt_q,
    output busy, done, err, sweep_rem, cnt_enable, cnt_load, cnt_up, cnt_d
  );

  modport master (
    output start, abort, lo, hi, sweeps, cnt_q,
    input  busy, done, err, sweep_rem, cnt_enable, cnt_load, cnt_up, cnt_d
  );
endinterface

// File: rtl/updown_sweep_controller.sv
// Triangle-sweep sequencer for an external loadable up/down counter.
// A run loads lo, counts up to hi, back down to lo, and repeats for the
// programmed number of sweeps. All counter controls are Moore outputs held in
// registers that are written together with the state, so they always match it.
module updown_sweep_controller #(
  parameter int BITS = 5,
  parameter int SW_W = 4
) (
  input logic                   clk,
  input logic                   reset_n,
  updown_sweep_controller_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_UP,
    S_DOWN,
    S_DONE
  } state_t;

  // Packed counter-control word: {enable, load, up, busy}
  typedef logic [3:0] ctl_t;

  state_t          state;
  ctl_t            ctl_r;
  logic [BITS-1:0] lo_r;
  logic [BITS-1:0] hi_r;
  logic [SW_W-1:0] sweep_rem_r;
  logic            done_r;
  logic            err_r;

  logic [BITS-1:0] turn_up;
  logic [BITS-1:0] turn_down;
  logic            start_ok;

  // Turnaround compares are made one step early: the counter moves on the
  // same edge the state changes, so it sits exactly on hi/lo at the turn.
  // Both are kept in BITS width; lo<hi guarantees neither wraps.
  function automatic logic [BITS-1:0] step_dn(input logic [BITS-1:0] v);
    return v - BITS'(1);
  endfunction

  function automatic logic [BITS-1:0] step_up(input logic [BITS-1:0] v);
    return v + BITS'(1);
  endfunction

  // Control word for the state being entered
  function automatic ctl_t ctl_of(input state_t s);
    case (s)
      S_LOAD:  return 4'b1101;
      S_UP:    return 4'b1011;
      S_DOWN:  return 4'b1001;
      default: return 4'b0000;
    endcase
  endfunction

  assign turn_up   = step_dn(hi_r);
  assign turn_down = step_up(lo_r);
  assign start_ok  = (bus.lo < bus.hi) && (bus.sweeps != '0);

  // Sweep sequencer: state, captured programming, remaining sweeps and pulses
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      ctl_r       <= ctl_of(S_IDLE);
      lo_r        <= '0;
      hi_r        <= '0;
      sweep_rem_r <= '0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      if (bus.abort) begin
        // Abort beats everything, including a start sampled in IDLE; the
        // counter is simply left un-enabled at whatever value it reached.
        state       <= S_IDLE;
        ctl_r       <= ctl_of(S_IDLE);
        sweep_rem_r <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.start) begin
              if (start_ok) begin
                lo_r        <= bus.lo;
                hi_r        <= bus.hi;
                sweep_rem_r <= bus.sweeps;
                state       <= S_LOAD;
                ctl_r       <= ctl_of(S_LOAD);
              end else begin
                err_r <= 1'b1;
              end
            end
          end
          S_LOAD: begin
            state <= S_UP;
            ctl_r <= ctl_of(S_UP);
          end
          S_UP: begin
            if (bus.cnt_q == turn_up) begin
              state <= S_DOWN;
              ctl_r <= ctl_of(S_DOWN);
            end
          end
          S_DOWN: begin
            if (bus.cnt_q == turn_down) begin
              if (sweep_rem_r == SW_W'(1)) begin
                sweep_rem_r <= '0;
                done_r      <= 1'b1;
                state       <= S_DONE;
                ctl_r       <= ctl_of(S_DONE);
              end else begin
                sweep_rem_r <= sweep_rem_r - SW_W'(1);
                state       <= S_UP;
                ctl_r       <= ctl_of(S_UP);
              end
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            ctl_r <= ctl_of(S_IDLE);
          end
          default: begin
            state <= S_IDLE;
            ctl_r <= ctl_of(S_IDLE);
          end
        endcase
      end
    end
  end

  assign bus.cnt_enable = ctl_r[3];
  assign bus.cnt_load   = ctl_r[2];
  assign bus.cnt_up     = ctl_r[1];
  assign bus.busy       = ctl_r[0];
  assign bus.cnt_d      = lo_r;
  assign bus.sweep_rem  = sweep_rem_r;
  assign bus.done       = done_r;
  assign bus.err        = err_r;

endmodule

// File: tb/tb_updown_sweep_controller.sv
// Bench for updown_sweep_controller: drives it with a real up/down counter,
// predicts the counter trace and done/err events from the sweep rules, and
// lets an independent monitor consume those predictions as the DUT produces them.
module tb_updown_sweep_controller;
  localparam int BITS = 5;
  localparam int SW_W = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  updown_sweep_controller_if #(.BITS(BITS), .SW_W(SW_W)) bus ();
  updown_sweep_controller #(.BITS(BITS), .SW_W(SW_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Controlled counter
  logic [BITS-1:0] cnt_q = '0;
  always @(posedge clk) begin
    if (bus.cnt_enable) begin
      if (bus.cnt_load)    cnt_q <= bus.cnt_d;
      else if (bus.cnt_up) cnt_q <= cnt_q + 1'b1;
      else                 cnt_q <= cnt_q - 1'b1;
    end
  end
  assign bus.cnt_q = cnt_q;

  int total_n = 0;
  int bad_n = 0;
  int exp_cnt[$];
  int exp_evt[$];   // 2 = done, 1 = err
  int en_cycles = 0;

  task automatic check(input string name, input int act, input int req);
    total_n++;
    if (act != req) begin
      bad_n++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Monitor: every enabled cycle yields one counter value; done/err yield events
  initial begin
    logic en_prev;
    int   ev;
    en_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (en_prev) begin
        if (exp_cnt.size() == 0) check("cnt_q_unexpected", int'(cnt_q), -1);
        else                     check("cnt_q_trace", int'(cnt_q), exp_cnt.pop_front());
      end
      if (bus.done || bus.err) begin
        ev = {bus.done, bus.err};
        if (exp_evt.size() == 0) check("event_unexpected", ev, 0);
        else                     check("event", ev, exp_evt.pop_front());
      end
      if (bus.cnt_enable) en_cycles++;
      en_prev = bus.cnt_enable;
    end
  end

  // Reference: the counter values of a whole run, in order
  task automatic push_trace(input int lo, input int hi, input int sw, input int keep);
    int seq[$];
    seq.push_back(lo);
    for (int s = 0; s < sw; s++) begin
      for (int v = lo + 1; v <= hi; v++) seq.push_back(v);
      for (int v = hi - 1; v >= lo; v--) seq.push_back(v);
    end
    for (int i = 0; i < keep; i++) exp_cnt.push_back(seq[i]);
  endtask

  // One run. cut=0 runs to completion; otherwise abort (or reset) is sampled on
  // the cut-th edge after the start edge. noise sprays starts while busy.
  task automatic run(input int lo, input int hi, input int sw, input int cut,
                     input bit use_reset, input bit noise);
    int total, d, en0, rem, last;
    d     = hi - lo;
    total = 1 + 2 * sw * d;
    last  = 0;
    if (cut == 0) begin
      push_trace(lo, hi, sw, total);
      exp_evt.push_back(2);
    end else begin
      push_trace(lo, hi, sw, cut);
      last = exp_cnt[exp_cnt.size() - 1];
    end
    en0 = en_cycles;
    bus.lo = BITS'(lo);
    bus.hi = BITS'(hi);
    bus.sweeps = SW_W'(sw);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int j = 0; j < total; j++) begin
      rem = (j == 0) ? sw : sw - (j - 1) / (2 * d);
      check("busy_in_run", int'(bus.busy), 1);
      check("sweep_rem", int'(bus.sweep_rem), rem);
      check("done_early", int'(bus.done), 0);
      if (j == 1) check("cnt_d", int'(bus.cnt_d), lo);
      if (noise) begin
        bus.start  = ($urandom_range(0, 2) == 0);
        bus.lo     = BITS'($urandom);
        bus.hi     = BITS'($urandom);
        bus.sweeps = SW_W'($urandom);
      end
      if (cut != 0 && j == cut - 1) begin
        bus.start = 1'b0;
        if (use_reset) reset_n = 1'b0;
        else           bus.abort = 1'b1;
        step();
        reset_n = 1'b1;
        bus.abort = 1'b0;
        check("stop_busy", int'(bus.busy), 0);
        check("stop_enable", int'(bus.cnt_enable), 0);
        check("stop_sweep_rem", int'(bus.sweep_rem), 0);
        check("stop_no_done", int'(bus.done), 0);
        check("stop_en_cycles", en_cycles - en0, cut);
        check("stop_cnt_q", int'(cnt_q), last);
        if (use_reset) begin
          check("reset_cnt_d", int'(bus.cnt_d), 0);
          step();
          step();
          check("reset_cnt_frozen", int'(cnt_q), last);
        end
        check("stop_trace_drained", exp_cnt.size(), 0);
        return;
      end
      step();
    end
    bus.start = 1'b0;
    check("done_pulse", int'(bus.done), 1);
    check("done_busy", int'(bus.busy), 0);
    check("done_enable", int'(bus.cnt_enable), 0);
    check("done_sweep_rem", int'(bus.sweep_rem), 0);
    step();
    check("done_one_cycle", int'(bus.done), 0);
    check("en_cycles", en_cycles - en0, total);
    check("trace_drained", exp_cnt.size(), 0);
    check("events_drained", exp_evt.size(), 0);
  endtask

  // Start in IDLE that must not launch a run: illegal programming, or abort held
  task automatic idle_start(input int lo, input int hi, input int sw, input bit with_abort);
    int en0;
    en0 = en_cycles;
    if (!with_abort) exp_evt.push_back(1);
    bus.lo = BITS'(lo);
    bus.hi = BITS'(hi);
    bus.sweeps = SW_W'(sw);
    bus.start = 1'b1;
    bus.abort = with_abort;
    step();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("idle_err", int'(bus.err), with_abort ? 0 : 1);
    check("idle_busy", int'(bus.busy), 0);
    check("idle_sweep_rem", int'(bus.sweep_rem), 0);
    step();
    check("idle_err_pulse", int'(bus.err), 0);
    check("idle_busy2", int'(bus.busy), 0);
    check("idle_no_enable", en_cycles - en0, 0);
    check("idle_events_drained", exp_evt.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lo, hi, sw, kind, total;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.lo = '0;
    bus.hi = '0;
    bus.sweeps = '0;
    reset_n = 1'b0;
    step();
    step();
    check("rst_busy", int'(bus.busy), 0);
    check("rst_enable", int'(bus.cnt_enable), 0);
    check("rst_load", int'(bus.cnt_load), 0);
    check("rst_up", int'(bus.cnt_up), 0);
    check("rst_cnt_d", int'(bus.cnt_d), 0);
    check("rst_sweep_rem", int'(bus.sweep_rem), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_err", int'(bus.err), 0);
    reset_n = 1'b1;
    step();

    run(2, 5, 2, 0, 1'b0, 1'b0);
    run(2, 5, 2, 3, 1'b1, 1'b0);
    idle_start(6, 6, 3, 1'b0);
    idle_start(1, 4, 0, 1'b0);
    idle_start(9, 3, 1, 1'b0);
    run(30, 31, 3, 0, 1'b0, 1'b0);
    run(0, 10, 1, 9, 1'b0, 1'b0);
    run(1, 3, 1, 0, 1'b0, 1'b0);
    run(2, 5, 1, 0, 1'b0, 1'b1);
    idle_start(1, 4, 2, 1'b1);
    run(0, 31, 1, 0, 1'b0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      kind = $urandom_range(0, 9);
      if (kind < 2) begin
        lo = $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 0) begin
          hi = $urandom_range(0, lo);
          sw = $urandom_range(0, 15);
        end else begin
          hi = (lo == 31) ? 31 : $urandom_range(lo + 1, 31);
          sw = 0;
        end
        idle_start(lo, hi, sw, 1'b0);
      end else begin
        lo = $urandom_range(0, 30);
        hi = $urandom_range(lo + 1, 31);
        sw = $urandom_range(1, 3);
        total = 1 + 2 * sw * (hi - lo);
        if (kind < 4) run(lo, hi, sw, $urandom_range(1, total), 1'b0, 1'b0);
        else          run(lo, hi, sw, 0, 1'b0, kind[0]);
      end
    end

    step();
    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end
endmodule

// File: doc/updown_sweep_controller.md
Name: updown_sweep_controller

Overview:
- Sequences an external loadable up/down counter (enable/load/up/D controls, registered Q fed back) through programmable triangle sweeps: load lo, count up to hi, count down to lo, repeated N times.
- Sits beside the counter in the basic-blocks datapath.
- Provides a start/busy/done handshake to the host, plus abort and an error pulse for illegal programming.

Parameters:
- BITS, 5, counter data width; must match the controlled counter.
- SW_W, 4, width of the sweep-count input and the remaining-sweeps counter.

Ports:
- clk  in  1  single clock, rising edge; counter runs on the same clock.
- reset_n  in  1  synchronous reset, active-low.
- start  in  1  request a new run; sampled only in IDLE.
- abort  in  1  terminate the run; honoured in any state.
- lo  in  BITS  sweep floor; captured on accepted start.
- hi  in  BITS  sweep ceiling; captured on accepted start.
- sweeps  in  SW_W  number of up+down passes; captured on accepted start.
- cnt_q  in  BITS  registered counter value (feedback).
- cnt_enable  out  1  counter enable.
- cnt_load  out  1  counter load select.
- cnt_up  out  1  counter direction: 1 = up, 0 = down.
- cnt_d  out  BITS  counter load value.
- busy  out  1  high in LOAD/UP/DOWN.
- done  out  1  one-cycle pulse on normal completion.
- err  out  1  one-cycle pulse on rejected start.
- sweep_rem  out  SW_W  sweeps remaining, including the current one.

Behaviour:
- Reset: reset_n is synchronous and active-low. On reset_n=0 at a clk edge: state=IDLE, lo_r=hi_r=0, sweep_rem=0, done=err=0. Therefore cnt_enable=cnt_load=cnt_up=0, cnt_d=0, busy=0. Applies mid-run; the counter is simply left un-enabled at its current value.
- Output decoding: all counter controls are decoded from the state register only (Moore).
  - cnt_d = lo_r in every state.
  - done and err are registered.
- IDLE:
  - Outputs: enable=0, load=0, up=0.
  - start=1 with lo<hi (unsigned) and sweeps!=0: capture lo/hi/sweeps into lo_r/hi_r/sweep_rem; next state LOAD.
  - start=1 with lo>=hi or sweeps==0: err=1 next cycle; stay IDLE; registers unchanged.
- LOAD:
  - Outputs: enable=1, load=1, up=0. The counter takes lo_r at this edge.
  - Next state: UP.
- UP:
  - Outputs: enable=1, load=0, up=1.
  - If cnt_q == hi_r-1: next state DOWN, so the counter is at hi_r on DOWN entry.
- DOWN:
  - Outputs: enable=1, load=0, up=0.
  - If cnt_q == lo_r+1 (counter reaches lo_r this edge):
    - sweep_rem == 1: next state DONE, sweep_rem := 0.
    - Otherwise: sweep_rem := sweep_rem-1, next state UP.
- DONE:
  - Outputs: enable=0. done=1 for exactly this cycle.
  - Next state: IDLE.
- Run timing:
  - Total enabled cycles = 1 + sweeps*2*(hi-lo).
  - done is high one cycle after the final decrement edge.
- abort:
  - abort=1 in LOAD/UP/DOWN/DONE: next state IDLE, sweep_rem := 0, no done pulse; the counter holds its value.
  - abort and start both high in IDLE: abort wins; start is ignored, no err.
- Busy rules:
  - start while busy is ignored; programming inputs are not re-sampled mid-run.
  - start is accepted again on the cycle after DONE (i.e. in IDLE).
- Boundaries:
  - hi-lo = 1 is legal: one UP cycle and one DOWN cycle per sweep.
  - hi = 2^BITS-1 is legal; hi_r-1 and lo_r+1 are computed in BITS width.
  - No wrap-around of the counter can occur given lo<hi.
- cnt_q is trusted. If the counter is disturbed externally, the compare simply waits for equality. Documented limitation; no timeout.

Test Plan:
- Reset mid-run: start lo=2 hi=5 sweeps=2, then reset_n=0 in UP at cnt_q=3 → next cycle busy=0, cnt_enable=0, sweep_rem=0, cnt_q frozen at 4.
- Nominal: lo=2 hi=5 sweeps=2 → LOAD then cnt_q 2,3,4,5,4,3,2,3,4,5,4,3,2; cnt_enable high 13 cycles; sweep_rem 2→1 at the first return to 2; done one pulse; busy falls with done.
- Illegal start: lo=6 hi=6 sweeps=3, then lo=1 hi=4 sweeps=0 → err one-cycle pulse each time, busy stays 0, cnt_enable never asserted.
- Minimum span and top of range: lo=30 hi=31 sweeps=3 (BITS=5) → cnt_q 30,31,30,31,30,31,30; done after 7 enabled cycles; no wrap to 0.
- Abort: start lo=0 hi=10 sweeps=1, abort at cnt_q=7 in UP → next cycle IDLE, no done, cnt_q holds 8; a new start the cycle after is accepted.
- Start while busy / simultaneous: start pulses during UP are ignored and sweep_rem is unchanged; abort=1 and start=1 together in IDLE → stays IDLE, no err.
